// File: rtl/qsys_pio_pulse_out.sv
// Avalon-MM output PIO with atomic set/clear, hardware-timed inverting pulses
// and an optional pulse-completion interrupt. Zero-wait-state slave.
module qsys_pio_pulse_out #(
  parameter int unsigned WIDTH                       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE            = '0,
  parameter int unsigned PULSE_LEN_W                 = 16,
  parameter logic [PULSE_LEN_W-1:0] PULSE_LEN_RESET  = PULSE_LEN_W'(1000)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_STATUS    = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE_GO  = 3'd6;

  typedef enum logic {
    IDLE    = 1'b0,
    PULSING = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       data_out, data_nxt;
  logic [WIDTH-1:0]       pulse_mask, mask_nxt;
  logic [PULSE_LEN_W-1:0] pulse_len, len_nxt;
  logic [PULSE_LEN_W-1:0] counter, cnt_nxt;
  logic                   done, done_nxt;
  logic                   irq_en, irq_en_nxt;

  logic                   wr;
  logic                   busy;
  logic [WIDTH-1:0]       wd_w;
  logic [PULSE_LEN_W-1:0] wd_len;
  logic                   unused_wd;

  assign wr        = chipselect & ~write_n;
  assign busy      = (state == PULSING);
  assign wd_w      = writedata[WIDTH-1:0];
  assign wd_len    = writedata[PULSE_LEN_W-1:0];
  assign unused_wd = ^writedata;

  // State and register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      data_out   <= RESET_VALUE;
      pulse_mask <= '0;
      pulse_len  <= PULSE_LEN_RESET;
      counter    <= '0;
      done       <= 1'b0;
      irq_en     <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_out   <= data_nxt;
      pulse_mask <= mask_nxt;
      pulse_len  <= len_nxt;
      counter    <= cnt_nxt;
      done       <= done_nxt;
      irq_en     <= irq_en_nxt;
    end
  end

  // Register writes and pulse sequencing; completion set overrides the W1C clear
  always_comb begin
    state_nxt  = state;
    data_nxt   = data_out;
    mask_nxt   = pulse_mask;
    len_nxt    = pulse_len;
    cnt_nxt    = counter;
    done_nxt   = done;
    irq_en_nxt = irq_en;

    if (wr) begin
      case (address)
        ADDR_DATA:      data_nxt   = wd_w;
        ADDR_PULSE_LEN: len_nxt    = wd_len;
        ADDR_STATUS:    if (writedata[1]) done_nxt = 1'b0;
        ADDR_IRQ_EN:    irq_en_nxt = writedata[0];
        ADDR_OUTSET:    data_nxt   = data_out | wd_w;
        ADDR_OUTCLEAR:  data_nxt   = data_out & ~wd_w;
        default:        ;
      endcase
    end

    case (state)
      IDLE: begin
        if (wr && (address == ADDR_PULSE_GO) && (wd_w != '0) && (pulse_len != '0)) begin
          state_nxt = PULSING;
          mask_nxt  = wd_w;
          cnt_nxt   = pulse_len;
        end
      end
      PULSING: begin
        if (counter == PULSE_LEN_W'(1)) begin
          state_nxt = IDLE;
          mask_nxt  = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = counter - PULSE_LEN_W'(1);
        end
      end
    endcase
  end

  assign out_port = data_out ^ pulse_mask;
  assign irq      = done & irq_en;

  // Zero-latency read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:      readdata = 32'(data_out);
      ADDR_PULSE_LEN: readdata = 32'(pulse_len);
      ADDR_STATUS:    readdata = {30'd0, done, busy};
      ADDR_IRQ_EN:    readdata = {31'd0, irq_en};
      ADDR_OUTSET:    readdata = 32'(out_port);
      ADDR_PULSE_GO:  readdata = 32'(pulse_mask);
      default:        readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_qsys_pio_pulse_out.sv
// Directed scoreboard bench for qsys_pio_pulse_out (WIDTH=4, RESET_VALUE=0x5).
module tb_qsys_pio_pulse_out;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;
  logic             irq;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  qsys_pio_pulse_out #(
    .WIDTH(WIDTH),
    .RESET_VALUE(4'h5),
    .PULSE_LEN_W(16),
    .PULSE_LEN_RESET(16'd1000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic compare(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed 0x%0h expected none", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", t, obs, e);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] v);
    expect_val(tag, v);
    compare(32'(out_port));
  endtask

  task automatic chk_irq(input string tag, input logic v);
    expect_val(tag, 32'(v));
    compare(32'(irq));
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] a, input logic [31:0] v);
    expect_val(tag, v);
    address = a;
    #1;
    compare(readdata);
  endtask

  // One-cycle write; returns at the negedge after the write edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;
    repeat (3) @(negedge clk);
    chk_out("reset_out", 32'h5);
    chk_irq("reset_irq", 1'b0);
    reset_n = 1'b1;
    cyc();
    chk_rd("reset_data", 3'd0, 32'h5);
    chk_rd("reset_len", 3'd1, 32'd1000);
    chk_rd("reset_status", 3'd2, 32'h0);

    // Base value updates: DATA, OUTSET, OUTCLEAR back to back
    wr(3'd0, 32'hA);
    chk_out("data_write", 32'hA);
    wr(3'd4, 32'h1);
    chk_out("outset", 32'hB);
    wr(3'd5, 32'h8);
    chk_out("outclear", 32'h3);
    chk_rd("rd_outset", 3'd4, 32'h3);
    chk_rd("rd_outclear", 3'd5, 32'h0);
    chk_rd("rd_reserved", 3'd7, 32'h0);

    // Pulse of length 3 with interrupt
    wr(3'd1, 32'd3);
    wr(3'd0, 32'h1);
    wr(3'd3, 32'h1);
    wr(3'd6, 32'h1);
    chk_out("pulseA_c1", 32'h0);
    chk_rd("pulseA_busy", 3'd2, 32'h1);
    chk_rd("pulseA_mask", 3'd6, 32'h1);
    chk_irq("pulseA_irq_low", 1'b0);
    cyc();
    chk_out("pulseA_c2", 32'h0);
    cyc();
    chk_out("pulseA_c3", 32'h0);
    cyc();
    chk_out("pulseA_end", 32'h1);
    chk_rd("pulseA_done", 3'd2, 32'h2);
    chk_irq("pulseA_irq", 1'b1);
    cyc();
    chk_irq("pulseA_irq_hold", 1'b1);
    wr(3'd2, 32'h2);
    chk_irq("pulseA_irq_clr", 1'b0);
    chk_rd("pulseA_status_clr", 3'd2, 32'h0);

    // Pulse of length 4: ignored GO, base change, len change, W1C on final edge
    wr(3'd1, 32'd4);
    wr(3'd6, 32'h1);
    chk_out("pulseB_c1", 32'h0);
    wr(3'd6, 32'h2);
    chk_rd("pulseB_mask_kept", 3'd6, 32'h1);
    chk_out("pulseB_c2", 32'h0);
    wr(3'd0, 32'h0);
    chk_out("pulseB_newbase", 32'h1);
    wr(3'd1, 32'd7);
    chk_out("pulseB_c4", 32'h1);
    wr(3'd2, 32'h2);
    chk_out("pulseB_end", 32'h0);
    chk_rd("pulseB_set_wins", 3'd2, 32'h2);
    wr(3'd2, 32'h2);
    chk_rd("pulseB_clr", 3'd2, 32'h0);
    chk_rd("pulseB_len_new", 3'd1, 32'd7);

    // Ignored starts while idle
    wr(3'd6, 32'h0);
    chk_rd("go_mask0_status", 3'd2, 32'h0);
    chk_rd("go_mask0_mask", 3'd6, 32'h0);
    wr(3'd1, 32'd0);
    wr(3'd6, 32'h1);
    chk_rd("go_len0_status", 3'd2, 32'h0);
    chk_out("go_len0_out", 32'h0);

    // Length-1 pulses: GO on the ending edge ignored, accepted one cycle later
    wr(3'd1, 32'd1);
    wr(3'd6, 32'h4);
    chk_out("len1_c1", 32'h4);
    wr(3'd6, 32'h4);
    chk_out("len1_end", 32'h0);
    chk_rd("len1_done", 3'd2, 32'h2);
    wr(3'd6, 32'h4);
    chk_out("len1_b2b", 32'h4);
    cyc();
    chk_out("len1_b2b_end", 32'h0);

    // Asynchronous reset mid-pulse
    wr(3'd1, 32'd5);
    wr(3'd6, 32'hF);
    chk_out("rst_pulse_on", 32'hF);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("rst_async_out", 32'h5);
    chk_irq("rst_async_irq", 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc();
    chk_rd("rst_status", 3'd2, 32'h0);
    chk_rd("rst_mask", 3'd6, 32'h0);
    cyc();
    chk_out("rst_out_after", 32'h5);

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qsys_pio_pulse_out.md
# qsys_pio_pulse_out

Parametrised Avalon-MM output PIO for the camera subsystem: drives a WIDTH-bit output port (sensor/MIPI resets, enables, power gates) from a CPU-writable register. It adds atomic set/clear, hardware-timed pulses that invert selected bits for a programmed number of cycles and then restore them, and an optional completion interrupt. It sits on the Qsys interconnect as a zero-wait-state slave, with out_port wired to top-level pins.

## Interface
- WIDTH, 1: output port width, 1..32
- RESET_VALUE, 0: value of the data register after reset (WIDTH bits)
- PULSE_LEN_W, 16: width of the pulse-length register and counter, 1..32
- PULSE_LEN_RESET, 1000: reset value of PULSE_LEN

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word register index
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above the register width are ignored
- readdata  out  32  combinational read data, zero-extended
- out_port  out  WIDTH  data_out XOR pulse_mask
- irq  out  1  done AND irq_en

## Operation
- A write occurs on a clock edge where chipselect=1 and write_n=0. There is no read strobe. readdata is a pure function of address and the registers (read latency 0).
- Register map:
  - 0 DATA, RW: data_out.
  - 1 PULSE_LEN, RW: pulse length in cycles.
  - 2 STATUS: read returns {30'b0, done, busy}. Writing 1 to bit1 clears done; bit0 is read-only.
  - 3 IRQ_EN, RW: bit0.
  - 4 OUTSET, W: data_out |= wd. Read returns out_port.
  - 5 OUTCLEAR, W: data_out &= ~wd. Read returns 0.
  - 6 PULSE_GO, W: start a pulse with mask wd[WIDTH-1:0]. Read returns pulse_mask.
  - 7: reserved. Write has no effect; read returns 0.
- Pulse start: a PULSE_GO write is accepted only when busy=0, mask≠0 and PULSE_LEN≠0. Otherwise it is silently ignored, with no state change and no done.
- On acceptance at edge E: pulse_mask←mask, counter←PULSE_LEN, busy←1.
- While busy, on each edge:
  - If counter=1: busy←0, pulse_mask←0, done←1.
  - Otherwise: counter←counter−1.
- Two states, IDLE (busy=0) and PULSING (busy=1). Transitions occur only as described above.
- DATA, OUTSET and OUTCLEAR writes while busy change the base value. The pulsed bits stay inverted relative to the new base.
- A PULSE_LEN write while busy takes effect on the next pulse only; the running counter is unaffected.
- A done set and a W1C clear on the same edge: set wins, done=1.
- Reset values: data_out=RESET_VALUE, pulse_mask=0, counter=0, busy=0, done=0, irq_en=0, PULSE_LEN=PULSE_LEN_RESET. Therefore out_port=RESET_VALUE and irq=0.
- An asserted reset_n=0 during a pulse aborts it immediately. out_port returns to RESET_VALUE asynchronously.

## Timing
- DATA/OUTSET/OUTCLEAR write at edge E: out_port changes after E (visible in the next cycle).
- PULSE_GO accepted at edge E with PULSE_LEN=N: pulsed bits are inverted from after E until after edge E+N, i.e. exactly N cycles.
- At edge E+N: busy→0 and done→1. irq rises after E+N if irq_en=1.
- A new PULSE_GO is accepted earliest at edge E+N+1, giving back-to-back pulses with no idle gap beyond one cycle.
- irq is combinational from registered done and irq_en, with no extra latency.
- PULSE_LEN=2^PULSE_LEN_W−1 must count fully, with no wrap-around.

## Test plan
- Reset with RESET_VALUE=0x5, WIDTH=4 → out_port=0x5, irq=0; reads give DATA=0x5, PULSE_LEN=1000, STATUS=0.
- Write DATA=0xA, then OUTSET 0x1, then OUTCLEAR 0x8 → out_port goes 0xA, 0xB, 0x3 on consecutive cycles; read addr 4 returns 0x3.
- PULSE_LEN=3, DATA=0x1, PULSE_GO 0x1 → out_port=0x0 for exactly 3 cycles, then 0x1. STATUS=0b01 during the pulse and 0b10 after. With IRQ_EN=1, irq=1 until STATUS is written 0x2.
- While busy, write PULSE_GO 0x2 → ignored, pulse_mask unchanged. Write PULSE_GO with mask 0 or with PULSE_LEN=0 when idle → no pulse and done stays 0.
- During a pulse, write DATA=0x0 → out_port=0x1 until the pulse ends, then 0x0. On the final pulse edge, also write STATUS=0x2 → done=1.
- Assert reset_n mid-pulse between edges → out_port=RESET_VALUE immediately; busy=0, done=0 after release.
